imem_arbiter: RTL and testbench

- Shares the single-port synchronous instruction memory between two requesters:
  - instruction fetch (IF stage);
  - a data-side port (MEM-stage loads/stores into instruction space, program download).
- Arbitrates per cycle, steers address/data to the memory, and routes the 1-cycle-latency read response back to the owner.
- Generates stall_IF for the fetch stage.
- Discards fetch responses killed by a branch redirect.

---
 rtl/imem_arb_pkg.sv | 27 ++
 rtl/imem_arb_prio.sv | 43 ++++
 rtl/imem_arbiter.sv | 117 +++++++++++
 tb/tb_imem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and address helpers for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA,
    OWN_DERR
  } owner_t;

  localparam int STREAK_W = 4;

  // 34-bit limit so base + 4*size cannot wrap at the top of the address map
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
    logic [33:0] lim;
    lim = {2'b00, base} + {size, 2'b00};
    return (addr >= base) && ({2'b00, addr} < lim);
  endfunction

  function automatic logic [31:0] byte_to_word(input logic [31:0] addr,
                                               input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/imem_arb_prio.sv
// Per-cycle grant pick: data first, except fetch gets a turn once the data
// streak while fetch waits reaches MAX_DATA_STREAK.
module imem_arb_prio
  import imem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic f_req,
  input  logic d_req,
  output logic f_gnt,
  output logic d_gnt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                fetch_turn;

  assign fetch_turn = f_req && (streak == STREAK_MAX);
  assign d_gnt      = d_req && !fetch_turn;
  assign f_gnt      = f_req && !d_gnt;

  always_comb begin
    streak_nxt = streak;
    if (f_gnt || !f_req) begin
      streak_nxt = '0;
    end else if (d_gnt && (streak != STREAK_MAX)) begin
      streak_nxt = streak + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch and the data side;
// issue is combinational, read data returns one cycle later to its owner.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE       = 32'h0000_0000,
  parameter int          IMEM_SIZE       = 32768,
  parameter int          ADDR_W          = 15,
  parameter int          MAX_DATA_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  input  logic              f_kill,
  output logic              f_gnt,
  output logic              stall_IF,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  logic        f_req_a;
  logic        d_req_a;
  logic        d_in;
  logic [31:0] f_word;
  logic [31:0] d_word;
  owner_t      owner;
  owner_t      owner_nxt;
  logic        kill;
  logic        kill_nxt;
  logic        was_write;
  logic        was_write_nxt;

  // Requests are masked in reset so every combinational output reads 0
  assign f_req_a = f_req && !RST;
  assign d_req_a = d_req && !RST;

  imem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .CLK  (CLK),
    .RST  (RST),
    .f_req(f_req_a),
    .d_req(d_req_a),
    .f_gnt(f_gnt),
    .d_gnt(d_gnt)
  );

  assign stall_IF = f_req_a && !f_gnt;
  assign f_word   = byte_to_word(f_addr, IMEM_BASE);
  assign d_word   = byte_to_word(d_addr, IMEM_BASE);
  assign d_in     = in_range(d_addr, IMEM_BASE, 32'(IMEM_SIZE));

  always_comb begin
    m_en          = 1'b0;
    m_we          = 4'b0000;
    m_addr        = '0;
    m_wdata       = '0;
    owner_nxt     = OWN_NONE;
    kill_nxt      = 1'b0;
    was_write_nxt = 1'b0;
    if (d_gnt) begin
      was_write_nxt = d_we;
      if (d_in) begin
        m_en   = 1'b1;
        m_addr = ADDR_W'(d_word);
        if (d_we) begin
          m_we    = d_wstrb;
          m_wdata = d_wdata;
        end else begin
          owner_nxt = OWN_DATA;
        end
      end else begin
        owner_nxt = OWN_DERR;
      end
    end else if (f_gnt) begin
      // Truncation to ADDR_W wraps out-of-range fetches modulo the depth
      m_en      = 1'b1;
      m_addr    = ADDR_W'(f_word);
      owner_nxt = OWN_FETCH;
      kill_nxt  = f_kill;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner     <= OWN_NONE;
      kill      <= 1'b0;
      was_write <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      kill      <= kill_nxt;
      was_write <= was_write_nxt;
    end
  end

  assign f_rvalid = (owner == OWN_FETCH) && !kill && !f_kill;
  assign f_rdata  = f_rvalid ? m_rdata : 32'h0;
  assign d_rvalid = (owner == OWN_DATA) || ((owner == OWN_DERR) && !was_write);
  assign d_rdata  = (owner == OWN_DATA) ? m_rdata : 32'h0;
  assign d_err    = (owner == OWN_DERR);

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed checks of imem_arbiter against a cycle-level model
// that tracks its own shadow memory and the pending response.
module tb_imem_arbiter;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          SIZE = 32768;
  localparam int          AW   = 15;
  localparam int          MAXS = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          f_req = 1'b0, f_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0]   f_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          f_gnt, stall_IF, f_rvalid, d_gnt, d_rvalid, d_err, m_en;
  logic [31:0]   f_rdata, d_rdata, m_wdata;
  logic [31:0]   m_rdata;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;

  imem_arbiter #(
    .IMEM_BASE(BASE), .IMEM_SIZE(SIZE), .ADDR_W(AW), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill), .f_gnt(f_gnt),
    .stall_IF(stall_IF), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err), .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory the DUT drives, and the model's independent copy
  logic [31:0] bram   [SIZE];
  logic [31:0] shadow [SIZE];

  always @(posedge CLK) begin
    if (m_en && m_we == 4'b0000) m_rdata <= bram[m_addr];
    else                         m_rdata <= $urandom;
    if (m_en)
      for (int b = 0; b < 4; b++)
        if (m_we[b]) bram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
  end

  // Model state: data-streak count and the response owed next cycle (kind 0 none, 1 fetch, 2 data, 3 error)
  int          streak = 0;
  int          p_kind = 0;
  bit          p_kill = 0, p_wr = 0;
  logic [31:0] p_data = '0;

  logic [15:0] gnt_hist = '0;
  logic [31:0] f_seen[$];
  logic [31:0] d_seen[$];
  int          derr_cnt = 0;

  always @(negedge CLK) begin
    bit e_fv, e_dv, e_dg, e_fg, d_ok, e_men;
    logic [3:0]  e_mwe;
    logic [31:0] e_wd, tmp;
    int          dw, fw, e_addr, n_kind;
    bit          n_kill, n_wr;
    logic [31:0] n_data;
    if (RST) begin
      chk("reset_ctl", {21'b0, f_gnt, d_gnt, stall_IF, f_rvalid, d_rvalid, d_err, m_en, m_we}, 32'h0);
      chk("reset_dat", m_wdata | f_rdata | d_rdata | 32'(m_addr), 32'h0);
      streak = 0;
      p_kind = 0;
    end else begin
      e_fv = (p_kind == 1) && !p_kill && !f_kill;
      e_dv = (p_kind == 2) || ((p_kind == 3) && !p_wr);
      chk("f_rvalid", 32'(f_rvalid), 32'(e_fv));
      chk("f_rdata", f_rdata, e_fv ? p_data : 32'h0);
      chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
      chk("d_rdata", d_rdata, (p_kind == 2) ? p_data : 32'h0);
      chk("d_err", 32'(d_err), 32'(p_kind == 3));
      if (f_rvalid) f_seen.push_back(f_rdata);
      if (d_rvalid) d_seen.push_back(d_rdata);
      if (d_err) derr_cnt++;

      e_dg = d_req && !((streak == MAXS) && f_req);
      e_fg = f_req && !e_dg;
      chk("f_gnt", 32'(f_gnt), 32'(e_fg));
      chk("d_gnt", 32'(d_gnt), 32'(e_dg));
      chk("stall_IF", 32'(stall_IF), 32'(f_req && !e_fg));
      gnt_hist = {gnt_hist[14:0], d_gnt};

      d_ok = (longint'(d_addr) >= longint'(BASE)) &&
             (longint'(d_addr) < longint'(BASE) + 4 * longint'(SIZE));
      tmp = (d_addr - BASE) >> 2;
      dw  = int'(tmp % SIZE);
      tmp = (f_addr - BASE) >> 2;
      fw  = int'(tmp % SIZE);
      n_kind = 0; n_kill = 0; n_wr = 0; n_data = '0;
      e_men = 0; e_mwe = '0; e_addr = 0; e_wd = '0;
      if (e_dg) begin
        n_wr = d_we;
        if (d_ok) begin
          e_men = 1; e_addr = dw;
          if (d_we) begin
            e_mwe = d_wstrb; e_wd = d_wdata;
            for (int b = 0; b < 4; b++)
              if (d_wstrb[b]) shadow[dw][8*b +: 8] = d_wdata[8*b +: 8];
          end else begin
            n_kind = 2; n_data = shadow[dw];
          end
        end else begin
          n_kind = 3;
        end
      end else if (e_fg) begin
        e_men = 1; e_addr = fw; n_kind = 1; n_kill = f_kill; n_data = shadow[fw];
      end
      chk("m_en", 32'(m_en), 32'(e_men));
      chk("m_we", 32'(m_we), 32'(e_mwe));
      if (e_men) chk("m_addr", 32'(m_addr), 32'(e_addr));
      if (e_mwe != 4'b0000) chk("m_wdata", m_wdata, e_wd);

      if (e_fg || !f_req) streak = 0;
      else if (e_dg && streak < MAXS) streak++;
      p_kind = n_kind; p_kill = n_kill; p_wr = n_wr; p_data = n_data;
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic fk,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] ds);
    f_req = fr; f_addr = fa; f_kill = fk;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = ds;
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < SIZE; i++) begin
      bram[i]   = (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
      shadow[i] = bram[i];
    end
    bram[4] = 32'hAAAA_0004; bram[5] = 32'hBBBB_0005; bram[6] = 32'hCCCC_0006;
    bram[2] = 32'h1122_3344; bram[9] = 32'h2424_2424;
    shadow[4] = bram[4]; shadow[5] = bram[5]; shadow[6] = bram[6];
    shadow[2] = bram[2]; shadow[9] = bram[9];

    repeat (2) @(posedge CLK);
    #1 RST = 0;
    idle();

    // Fetch stream 0x10, 0x14, 0x18
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h14, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h18, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t1_count", 32'(f_seen.size()), 32'd3);
    if (f_seen.size() == 3) begin
      chk("t1_A", f_seen[0], 32'hAAAA_0004);
      chk("t1_B", f_seen[1], 32'hBBBB_0005);
      chk("t1_C", f_seen[2], 32'hCCCC_0006);
    end

    // Fetch and data contending: DDDDF repeating
    for (int i = 0; i < 10; i++) drive(1, 32'h44, 0, 1, 0, 32'h40, 0, 0);
    idle();
    chk("t2_pattern", 32'(gnt_hist[10:1]), 32'(10'b11_1101_1110));

    // Kill in the grant cycle, then kill in the response cycle
    n0 = f_seen.size();
    drive(1, 32'h20, 1, 0, 0, 0, 0, 0);
    idle();
    drive(1, 32'h20, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("t3_killed", 32'(f_seen.size() - n0), 32'd0);
    drive(1, 32'h24, 0, 0, 0, 0, 0, 0);
    idle();
    chk("t3_next", f_seen[$], 32'h2424_2424);

    // Partial write then read back
    drive(0, 0, 0, 1, 1, 32'h8, 32'hDEAD_BEEF, 4'b0011);
    drive(0, 0, 0, 1, 0, 32'h8, 0, 0);
    idle();
    chk("t4_merge", d_seen[$], 32'h1122_BEEF);

    // Out-of-range read
    n0 = derr_cnt;
    drive(0, 0, 0, 1, 0, 32'h0002_0000, 0, 0);
    idle();
    chk("t5_err", 32'(derr_cnt - n0), 32'd1);
    chk("t5_rdata", d_seen[$], 32'h0);

    // Reset the cycle after a data read grant
    n0 = d_seen.size();
    drive(0, 0, 0, 1, 0, 32'h8, 0, 0);
    RST = 1; f_req = 1; d_req = 1;
    @(posedge CLK); #1;
    RST = 0;
    idle();
    chk("t6_no_rvalid", 32'(d_seen.size() - n0), 32'd0);
    for (int i = 0; i < 5; i++) drive(1, 32'h44, 0, 1, 0, 32'h40, 0, 0);
    idle();
    chk("t6_streak0", 32'(gnt_hist[5:1]), 32'(5'b11110));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] fa, da;
      fa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      da = ($urandom_range(0, 9) == 0) ? 32'h0002_0000 + 32'($urandom_range(0, 4000))
                                       : 32'($urandom_range(0, 255));
      drive($urandom_range(0, 9) < 7, fa, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, da,
            $urandom, 4'($urandom_range(0, 15)));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
